// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC unit: FSM states, PC step size and
// the redirect-select encoding produced by the target selector.
// Ports: none (package only).
package pc_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Bundle between the ID stage (master: redirect requests, stall) and the
// PC unit (slave: fetch address, flush/valid/misalign status).
// Ports: stall/branch/jump/jr requests in, pc/pc_plus4/flush/valid/misalign out.
interface pc_next_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall_i;
    logic             branch_taken_i;
    logic [WIDTH-1:0] branch_off_i;
    logic             jump_i;
    logic [25:0]      jump_idx_i;
    logic             jr_i;
    logic [WIDTH-1:0] jr_addr_i;
    logic [WIDTH-1:0] pc_o;
    logic [WIDTH-1:0] pc_plus4_o;
    logic             flush_o;
    logic             valid_o;
    logic             misalign_o;

    modport master (
        output stall_i, branch_taken_i, branch_off_i, jump_i, jump_idx_i,
               jr_i, jr_addr_i,
        input  pc_o, pc_plus4_o, flush_o, valid_o, misalign_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_off_i, jump_i, jump_idx_i,
               jr_i, jr_addr_i,
        output pc_o, pc_plus4_o, flush_o, valid_o, misalign_o
    );
endinterface

// File: rtl/pc_target_sel.sv
// Purpose: priority select (jr > jump > branch > sequential) and target math.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stall/state gating is applied by the caller.
// Ports: hist_i/seq_pc_i context, redirect requests in; sel_o, target_o,
//        jr_misalign_o out.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hist_i,
    input  logic [WIDTH-1:0] seq_pc_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_off_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_idx_i,
    input  logic             jr_i,
    input  logic [WIDTH-1:0] jr_addr_i,
    output sel_e             sel_o,
    output logic [WIDTH-1:0] target_o,
    output logic             jr_misalign_o
);

    always_comb begin
        sel_o    = SEL_SEQ;
        target_o = seq_pc_i;
        if (jr_i) begin
            sel_o    = SEL_JR;
            // Low bits are dropped, not trapped; misalign is only reported.
            target_o = {jr_addr_i[WIDTH-1:2], 2'b00};
        end else if (jump_i) begin
            sel_o    = SEL_J;
            // Region bits come from the jump's own pc+4, not the fetch pc.
            target_o = {hist_i[WIDTH-1:28], jump_idx_i, 2'b00};
        end else if (branch_taken_i) begin
            sel_o    = SEL_BR;
            target_o = hist_i + branch_off_i;
        end
    end

    assign jr_misalign_o = jr_i && (jr_addr_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_next_unit.sv
// Purpose: fetch PC register, next-PC FSM (HOLD/RUN/FLUSH), one-cycle flush.
// Latency: redirect seen in cycle N -> new pc_o and flush_o in cycle N+1.
// Backpressure: stall_i holds pc/history and masks redirects for that cycle.
// Ports: clk, rst_n (sync, active low); bus = pc_next_unit_if slave modport.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_next_unit_if.slave bus
);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] hist_q;      // pc+4 of the instruction currently in ID
    logic             flush_q;
    logic             valid_q;
    logic             misalign_q;

    logic [WIDTH-1:0] pc_plus4;
    sel_e             sel;
    logic [WIDTH-1:0] target;
    logic             jr_misalign;

    assign pc_plus4 = pc_q + WIDTH'(PC_STEP);

    pc_target_sel #(.WIDTH(WIDTH)) u_target_sel (
        .hist_i         (hist_q),
        .seq_pc_i       (pc_plus4),
        .branch_taken_i (bus.branch_taken_i),
        .branch_off_i   (bus.branch_off_i),
        .jump_i         (bus.jump_i),
        .jump_idx_i     (bus.jump_idx_i),
        .jr_i           (bus.jr_i),
        .jr_addr_i      (bus.jr_addr_i),
        .sel_o          (sel),
        .target_o       (target),
        .jr_misalign_o  (jr_misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            pc_q       <= RESET_PC;
            hist_q     <= RESET_PC;
            flush_q    <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // Pulses default low; set only on the edge that redirects.
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (!bus.stall_i) begin
                        pc_q   <= target;
                        hist_q <= target;
                        if (sel != SEL_SEQ) begin
                            state_q    <= FLUSH;
                            flush_q    <= 1'b1;
                            misalign_q <= jr_misalign;
                        end
                    end
                end
                FLUSH: begin
                    // Redirect requests here belong to the squashed slot.
                    if (!bus.stall_i) begin
                        pc_q   <= pc_plus4;
                        hist_q <= pc_plus4;
                    end
                    state_q <= RUN;
                end
                default: begin
                    state_q <= HOLD;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus4;
    assign bus.flush_o    = flush_q;
    assign bus.valid_o    = valid_q;
    assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: two instances (RESET_PC=0 and
// RESET_PC=FFFF_FFF8) share stimulus; a reference model predicts outputs.
module tb_pc_next_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_next_unit_if #(.WIDTH(32)) bus0 ();
    pc_next_unit_if #(.WIDTH(32)) bus1 ();

    pc_next_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    pc_next_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference model: phase 0 = just out of reset (fetch not yet valid),
    // 1 = normal fetch, 2 = first fetch at a redirect target.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] seq_base;   // pc+4 of the instruction sitting in ID
        int          phase;
        bit          mis;
    } mdl_t;

    mdl_t m0, m1;
    logic [66:0] q0[$];
    logic [66:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic mdl_t step(mdl_t m, logic [31:0] rpc, bit rst, bit stall,
                                  bit br, logic [31:0] off, bit j,
                                  logic [25:0] idx, bit jr, logic [31:0] addr);
        mdl_t n;
        logic [31:0] tgt;
        n = m;
        n.mis = 1'b0;
        if (!rst) begin
            n.pc = rpc; n.seq_base = rpc; n.phase = 0;
            return n;
        end
        if (m.phase == 0) begin
            n.phase = 1;
        end else if (m.phase == 2) begin
            if (!stall) begin
                n.pc = m.pc + 32'd4; n.seq_base = n.pc;
            end
            n.phase = 1;
        end else if (!stall) begin
            if (jr || j || br) begin
                if (jr) begin
                    tgt = addr & 32'hFFFF_FFFC;
                    n.mis = (addr % 4) != 0;
                end else if (j) begin
                    tgt = (m.seq_base & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
                end else begin
                    tgt = m.seq_base + off;
                end
                n.pc = tgt; n.seq_base = tgt; n.phase = 2;
            end else begin
                n.pc = m.pc + 32'd4; n.seq_base = n.pc;
            end
        end
        return n;
    endfunction

    function automatic logic [66:0] expect_of(mdl_t m);
        return {m.pc, m.pc + 32'd4, m.phase == 2, m.phase != 0, m.mis};
    endfunction

    task automatic drive(input bit rst, input bit stall, input bit br,
                         input logic [31:0] off, input bit j, input logic [25:0] idx,
                         input bit jr, input logic [31:0] addr);
        @(negedge clk);
        rst_n = rst;
        bus0.stall_i = stall; bus0.branch_taken_i = br; bus0.branch_off_i = off;
        bus0.jump_i = j; bus0.jump_idx_i = idx; bus0.jr_i = jr; bus0.jr_addr_i = addr;
        bus1.stall_i = stall; bus1.branch_taken_i = br; bus1.branch_off_i = off;
        bus1.jump_i = j; bus1.jump_idx_i = idx; bus1.jr_i = jr; bus1.jr_addr_i = addr;
        m0 = step(m0, 32'h0000_0000, rst, stall, br, off, j, idx, jr, addr);
        m1 = step(m1, 32'hFFFF_FFF8, rst, stall, br, off, j, idx, jr, addr);
        q0.push_back(expect_of(m0));
        q1.push_back(expect_of(m1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    task automatic do_jr(input logic [31:0] addr);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, addr);
    endtask

    // Monitor: every cycle the DUTs present a fetch slot; compare it with
    // the oldest prediction.
    initial begin
        logic [66:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {bus0.pc_o, bus0.pc_plus4_o, bus0.flush_o, bus0.valid_o, bus0.misalign_o};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL dut0_slot cyc=%0d got pc=%h p4=%h fl=%b v=%b mis=%b exp pc=%h p4=%h fl=%b v=%b mis=%b",
                             cyc, a[66:35], a[34:3], a[2], a[1], a[0],
                             e[66:35], e[34:3], e[2], e[1], e[0]);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {bus1.pc_o, bus1.pc_plus4_o, bus1.flush_o, bus1.valid_o, bus1.misalign_o};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL dut1_slot cyc=%0d got pc=%h p4=%h fl=%b v=%b mis=%b exp pc=%h p4=%h fl=%b v=%b mis=%b",
                             cyc, a[66:35], a[34:3], a[2], a[1], a[0],
                             e[66:35], e[34:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        m0 = '{pc: 32'd0, seq_base: 32'd0, phase: 0, mis: 1'b0};
        m1 = m0;
        bus0.stall_i = 1'b0; bus0.branch_taken_i = 1'b0; bus0.branch_off_i = '0;
        bus0.jump_i = 1'b0; bus0.jump_idx_i = '0; bus0.jr_i = 1'b0; bus0.jr_addr_i = '0;
        bus1.stall_i = 1'b0; bus1.branch_taken_i = 1'b0; bus1.branch_off_i = '0;
        bus1.jump_i = 1'b0; bus1.jump_idx_i = '0; bus1.jr_i = 1'b0; bus1.jr_addr_i = '0;

        // Reset two cycles, then HOLD and sequential fetch up to pc 0x10
        // (dut1 wraps FFFF_FFF8 -> FFFF_FFFC -> 0 here).
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        idle(5);
        // Backward branch from 0x10 to 0x0, then sequential.
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0);
        idle(2);
        // All three redirects at once: jr wins; then misaligned jr.
        drive(1'b1, 1'b0, 1'b1, 32'd8, 1'b1, 26'h10, 1'b1, 32'h0000_0400);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 32'd8, 1'b1, 26'h10, 1'b1, 32'h0000_0403);
        idle(2);
        // Land at 0x9000_0040 in RUN, jump to 0x9000_048C, branch in FLUSH ignored.
        do_jr(32'h9000_003C);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h0000123, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 26'd0, 1'b0, 32'd0);
        idle(1);
        // Stall at 0x20 with a taken branch for three cycles.
        do_jr(32'h0000_001C);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 26'd0, 1'b0, 32'd0);
        idle(2);
        // Reset asserted during the FLUSH cycle.
        do_jr(32'h0000_0100);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 149) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 5) == 0, 26'($urandom),
                  $urandom_range(0, 6) == 0, $urandom);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain got q0=%0d q1=%0d leftover exp 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
